// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings and read-master state shared by the read-channel initiator.
package axi_pkg;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam int AXI_4K_BYTES = 4096;
   typedef enum logic [1:0] {RM_IDLE, RM_ADDR, RM_DATA} rm_state_t;
endpackage

// File: rtl/axi_burst_len_calc.sv
// axi_burst_len_calc: beats of the next burst = min(remaining, MAX_BURST_LEN, beats left in the 4 KB page).
module axi_burst_len_calc
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = 4,
   parameter int MAX_BURST_LEN = 256
) (
   input  logic [16:0] remaining,
   input  logic [11:0] page_off,
   output logic [8:0]  beats,
   output logic [7:0]  arlen
);
   localparam int SIZE = $clog2(STRB_WIDTH);
   logic [8:0]  cap_len;
   logic [12:0] room;
   assign cap_len = (remaining > 17'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : remaining[8:0];
   generate
      if (ADDR_WIDTH >= 13) begin : g_4k
         assign room = (13'(AXI_4K_BYTES) - {1'b0, page_off}) >> SIZE;
      end else begin : g_flat
         logic unused_off;
         assign unused_off = ^page_off;
         assign room = 13'(cap_len);
      end
   endgenerate
   assign beats = ({4'b0, cap_len} > room) ? 9'(room) : cap_len;
   assign arlen = 8'(beats - 9'd1);
endmodule

// File: rtl/axi_read_master.sv
// axi_read_master: splits one read command into 4 KB-safe INCR bursts and streams R data out on AXI-Stream.
// Define AXI_READ_MASTER_ERR_ABORT_EN to stop issuing bursts once an error response has been seen.
module axi_read_master
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH = 8,
   parameter int AR_ID = 0,
   parameter int MAX_BURST_LEN = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [15:0]           cmd_len,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic                  busy,
   output logic                  err,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);
   localparam int SIZE = $clog2(STRB_WIDTH);
   rm_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr;
   logic [16:0]           remaining, rem_eff;
   logic [7:0]            beat_cnt, arlen;
   logic [8:0]            beats;
   logic                  ready_q, cmd_fire, r_fire, abort, unused_ok;

   axi_burst_len_calc #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .STRB_WIDTH(STRB_WIDTH),
      .MAX_BURST_LEN(MAX_BURST_LEN)
   ) u_len (
      .remaining(remaining),
      .page_off(12'(addr)),
      .beats(beats),
      .arlen(arlen)
   );

   // rlast and rid are not needed: the beat counter alone delimits bursts
   assign unused_ok = ^{m_axi_rid, m_axi_rlast};

`ifdef AXI_READ_MASTER_ERR_ABORT_EN
   // the beat carrying the first error already counts, so tlast lands on that burst's final beat
   assign abort = err | (m_axi_rvalid & (m_axi_rresp != AXI_RESP_OKAY));
`else
   assign abort = 1'b0;
`endif

   assign rem_eff = abort ? '0 : remaining;
   assign cmd_fire = cmd_valid & ready_q;
   assign cmd_ready = ready_q;
   assign busy = state != RM_IDLE;
   assign m_axi_arid = ID_WIDTH'(AR_ID);
   assign m_axi_araddr = addr;
   assign m_axi_arlen = arlen;
   assign m_axi_arsize = 3'(SIZE);
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot = 3'b000;
   assign m_axi_arvalid = state == RM_ADDR;
   assign m_axi_rready = (state == RM_DATA) & m_axis_tready;
   assign m_axis_tvalid = (state == RM_DATA) & m_axi_rvalid;
   assign m_axis_tdata = m_axi_rdata;
   assign m_axis_tlast = (state == RM_DATA) && beat_cnt == '0 && rem_eff == '0;
   assign r_fire = m_axis_tvalid & m_axi_rready;

   always_comb begin
      state_nxt = state;
      case (state)
         RM_IDLE: state_nxt = cmd_fire ? RM_ADDR : RM_IDLE;
         RM_ADDR: state_nxt = m_axi_arready ? RM_DATA : RM_ADDR;
         RM_DATA: state_nxt = (r_fire && beat_cnt == '0) ? ((rem_eff != '0) ? RM_ADDR : RM_IDLE) : RM_DATA;
         default: state_nxt = RM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RM_IDLE;
         ready_q <= 1'b0;
         addr <= '0;
         remaining <= '0;
         beat_cnt <= '0;
         err <= 1'b0;
      end else begin
         state <= state_nxt;
         ready_q <= state_nxt == RM_IDLE;
         if (cmd_fire) begin
            addr <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining <= 17'(cmd_len) + 17'd1;
         end
         if (state == RM_ADDR && m_axi_arready) begin
            addr <= addr + ADDR_WIDTH'(beats) * ADDR_WIDTH'(STRB_WIDTH);
            remaining <= remaining - 17'(beats);
            beat_cnt <= arlen;
         end
         if (r_fire && beat_cnt != '0) beat_cnt <= beat_cnt - 8'd1;
         if (cmd_fire) err <= 1'b0;
         else if (r_fire && m_axi_rresp != AXI_RESP_OKAY) err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: table and random commands against a RAM responder and a burst-splitting reference model.
module tb_axi_read_master;
   logic        clk, rst_n;
   logic [15:0] cmd_addr, cmd_len;
   logic        cmd_valid, cmd_ready, busy, err;
   logic [7:0]  m_axi_arid, m_axi_arlen, m_axi_rid;
   logic [15:0] m_axi_araddr;
   logic [2:0]  m_axi_arsize, m_axi_arprot;
   logic [1:0]  m_axi_arburst, m_axi_rresp;
   logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
   logic [3:0]  m_axi_arcache;
   logic [31:0] m_axi_rdata, m_axis_tdata;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

   axi_read_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .busy(busy), .err(err),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int len, err_at, mode, n_ar, arlen0, beats;
   } vec_t;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, last_cyc = -1, idle_cyc = -1, proto_bad = 0, stall_low = 0, stall_left = 0;
   int n_st = 0, gbeat = 0, err_at = -1, tmode = 0, r_left = 0;
   logic [15:0] r_addr = '0, ar_a = '0, ar_ah = '0;
   logic [7:0]  ar_l = '0, ar_lh = '0;
   logic        ar_f = 0, r_f = 0, s_f = 0, s_last = 0, ar_hold = 0, busy_prev = 0;
   logic [31:0] s_data = '0;
   logic        exp_err, prev_err = 0;
   logic [23:0] ar_log[$], exp_ar[$];
   logic [32:0] st_log[$], exp_st[$];

   function automatic logic [31:0] word(input logic [15:0] a);
      logic [15:0] i;
      i = {2'b00, a[15:2]};
      return {~i, i};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // one clock of responder + stream sink; samples outputs 1 ns after the falling edge
   task automatic step();
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         m_axi_arready = 0;
         m_axi_rvalid = 0;
         r_left = 0;
      end else begin
         if (ar_f) begin
            r_addr = ar_a;
            r_left = int'(ar_l) + 1;
            ar_log.push_back({ar_a, ar_l});
         end
         if (r_f) begin
            r_addr += 16'd4;
            r_left--;
            gbeat++;
         end
         if (s_f) begin
            st_log.push_back({s_last, s_data});
            n_st++;
            if (tmode == 2 && n_st == 2) stall_left = 5;
         end
         m_axi_arready = $urandom_range(0, 2) != 0;
         if (!m_axi_rvalid || r_f) begin
            m_axi_rvalid = r_left > 0 && $urandom_range(0, 3) != 0;
            m_axi_rdata = word(r_addr);
            m_axi_rresp = (gbeat == err_at) ? 2'b10 : 2'b00;
            m_axi_rlast = r_left == 1;
         end
         if (tmode == 2 && stall_left > 0) begin
            m_axis_tready = 0;
            stall_left--;
         end else m_axis_tready = (tmode != 1) || $urandom_range(0, 3) != 0;
      end
      #1;
      if (m_axi_arvalid && (m_axi_arsize != 3'd2 || m_axi_arburst != 2'b01 || m_axi_arid != 8'd0 ||
          m_axi_arlock || m_axi_arcache != 4'b0011 || m_axi_arprot != 3'd0)) proto_bad++;
      if (rst_n && ar_hold && (!m_axi_arvalid || m_axi_araddr != ar_ah || m_axi_arlen != ar_lh)) proto_bad++;
      if (m_axis_tvalid != m_axi_rvalid) proto_bad++;
      if (m_axi_rvalid && (m_axis_tdata != m_axi_rdata || m_axi_rready != m_axis_tready)) proto_bad++;
      if (!busy && (m_axi_rready || m_axi_arvalid)) proto_bad++;
      if (tmode == 2 && busy && !m_axis_tready && !m_axi_rready) stall_low++;
      ar_f = m_axi_arvalid && m_axi_arready;
      ar_a = m_axi_araddr;
      ar_l = m_axi_arlen;
      ar_hold = m_axi_arvalid && !m_axi_arready;
      ar_ah = m_axi_araddr;
      ar_lh = m_axi_arlen;
      r_f = m_axi_rvalid && m_axi_rready;
      s_f = m_axis_tvalid && m_axis_tready;
      s_data = m_axis_tdata;
      s_last = m_axis_tlast;
      if (s_f && s_last) last_cyc = cyc;
      if (busy_prev && !busy) idle_cyc = cyc;
      busy_prev = busy;
   endtask

   // expected bursts and stream straight from the splitting rules
   task automatic model(input logic [15:0] a0, input int len, input int ea);
      int a, rem, n, beat;
      bit stop;
      exp_ar.delete();
      exp_st.delete();
      a = int'(a0) & 'hFFFC;
      rem = len + 1;
      beat = 0;
      stop = 0;
      exp_err = ea >= 0 && ea <= len;
      while (rem > 0 && !stop) begin
         n = rem < 256 ? rem : 256;
         if (n > (4096 - a % 4096) / 4) n = (4096 - a % 4096) / 4;
         exp_ar.push_back({16'(a), 8'(n - 1)});
         for (int k = 0; k < n; k++) begin
            exp_st.push_back({1'b0, word(16'(a + 4 * k))});
`ifdef AXI_READ_MASTER_ERR_ABORT_EN
            if (beat == ea) stop = 1;
`endif
            beat++;
         end
         rem -= n;
         a = (a + 4 * n) % 65536;
      end
      exp_st[exp_st.size() - 1][32] = 1'b1;
   endtask

   task automatic issue(input logic [15:0] a, input int len);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         step();
         n++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_addr = a;
      cmd_len = 16'(len);
      cmd_valid = 1;
      gbeat = 0;
      step();
      cmd_valid = 0;
   endtask

   task automatic run_cmd(input logic [15:0] a, input int len, input int ea, input int mode);
      int n = 0;
      model(a, len, ea);
      ar_log.delete();
      st_log.delete();
      proto_bad = 0;
      stall_low = 0;
      stall_left = 0;
      n_st = 0;
      err_at = ea;
      tmode = mode;
      last_cyc = -1;
      idle_cyc = -1;
      check("err_sticky", err, prev_err);
      issue(a, len);
      check("err_clear_on_accept", err, 0);
      check("busy_set", busy, 1);
      while (busy && n < 5000) begin
         step();
         n++;
      end
      check("busy_timeout", busy, 0);
      step();
      check("ar_count", ar_log.size(), exp_ar.size());
      foreach (exp_ar[i]) if (i < ar_log.size()) check($sformatf("ar%0d", i), ar_log[i], exp_ar[i]);
      check("beat_count", st_log.size(), exp_st.size());
      foreach (exp_st[i]) if (i < st_log.size()) check($sformatf("beat%0d", i), st_log[i], exp_st[i]);
      check("err", err, exp_err);
      check("busy_fall_after_tlast", idle_cyc - last_cyc, 1);
      if (mode == 2) check("stall_rready_low", stall_low, 5);
      check("protocol", proto_bad, 0);
      prev_err = exp_err;
   endtask

   initial begin
      vec_t tv[9];
      int n;
      tv[0] = '{16'h0100, 3, -1, 0, 1, 3, 4};
      tv[1] = '{16'h0000, 299, -1, 1, 2, 255, 300};
      tv[2] = '{16'h0FF8, 3, -1, 1, 2, 1, 4};
      tv[3] = '{16'h0200, 7, -1, 2, 1, 7, 8};
`ifdef AXI_READ_MASTER_ERR_ABORT_EN
      tv[4] = '{16'h0FF0, 7, 1, 1, 1, 3, 4};
`else
      tv[4] = '{16'h0FF0, 7, 1, 1, 2, 3, 8};
`endif
      tv[5] = '{16'h0103, 0, -1, 0, 1, 0, 1};
      tv[6] = '{16'hFFF8, 3, -1, 1, 2, 1, 4};
      tv[7] = '{16'h0000, 255, -1, 1, 1, 255, 256};
      tv[8] = '{16'h0F00, 600, 599, 1, 4, 63, 601};
      rst_n = 0;
      cmd_valid = 0;
      cmd_addr = '0;
      cmd_len = '0;
      m_axi_arready = 0;
      m_axi_rid = '0;
      m_axi_rdata = '0;
      m_axi_rresp = '0;
      m_axi_rlast = 0;
      m_axi_rvalid = 0;
      m_axis_tready = 0;
      step();
      step();
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_arvalid", m_axi_arvalid, 0);
      rst_n = 1;
      step();
      check("ready_after_reset", cmd_ready, 1);

      for (int i = 0; i < 9; i++) begin
         run_cmd(tv[i].addr, tv[i].len, tv[i].err_at, tv[i].mode);
         check($sformatf("vec%0d_n_ar", i), ar_log.size(), tv[i].n_ar);
         check($sformatf("vec%0d_arlen0", i), ar_log.size() > 0 ? int'(ar_log[0][7:0]) : -1, tv[i].arlen0);
         check($sformatf("vec%0d_beats", i), st_log.size(), tv[i].beats);
      end

      tmode = 1;
      err_at = -1;
      ar_log.delete();
      st_log.delete();
      n_st = 0;
      issue(16'h0000, 99);
      n = 0;
      while (st_log.size() < 5 && n < 2000) begin
         step();
         n++;
      end
      check("reset_reach_data", st_log.size() >= 5, 1);
      rst_n = 0;
      #1;
      check("rst_data_arvalid", m_axi_arvalid, 0);
      check("rst_data_tvalid", m_axis_tvalid, 0);
      check("rst_data_rready", m_axi_rready, 0);
      check("rst_data_busy", busy, 0);
      check("rst_data_cmd_ready", cmd_ready, 0);
      step();
      step();
      rst_n = 1;
      #1;
      check("ready_before_edge", cmd_ready, 0);
      step();
      check("ready_after_release", cmd_ready, 1);
      prev_err = 0;
      run_cmd(16'h0040, 9, -1, 1);

      for (int i = 0; i < 12; i++) begin
         logic [15:0] a;
         int len, ea;
         a = 16'($urandom) & 16'hFFFC;
         if ($urandom_range(0, 1) == 1) a = {a[15:12], 4'hF, a[7:2], 2'b00};
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 700)) : int'($urandom_range(0, 40));
         ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         run_cmd(a, len, ea, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
